// File: rtl/switch_poll_pkg.sv
// Shared types and ASCII helpers for the switch polling controller.
package switch_poll_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    SAMPLE,
    SEND_HI,
    SEND_LO,
    SEND_NL
  } state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Upper-case hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return ASCII_0 + {4'd0, n};
    end
    return ASCII_A + {4'd0, n} - 8'd10;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Debounce filter: tracks the candidate switch value and how many consecutive
// polls have returned it, and flags when a new value is accepted.
module switch_debounce
  import switch_poll_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [7:0] sample,
  input  logic [7:0] sw_state,
  output logic       accept
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_CNT);

  logic [7:0] cand;
  logic [3:0] stable_cnt;
  logic [3:0] cnt_next;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_next = 4'd1;
    if (sample == cand) begin
      cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + 4'd1;
    end
  end

  // The candidate after this sample always equals the sample itself.
  assign accept = sample_en && (cnt_next == CNT_MAX) && (sample != sw_state);

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand       <= '0;
      stable_cnt <= '0;
    end else if (sample_en) begin
      cand       <= sample;
      stable_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/switch_poll_ctrl.sv
// Switch PIO poller: periodic read, debounce, and a 3-byte ASCII report per change.
// Optional interrupt output is built when SWITCH_POLL_IRQ_EN is defined.
module switch_poll_ctrl
  import switch_poll_pkg::*;
#(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  pio_address,
  input  logic [31:0] pio_readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  sw_state,
  output logic        sw_changed
`ifdef SWITCH_POLL_IRQ_EN
  ,
  output logic        irq,
  input  logic        irq_ack
`endif
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(POLL_DIV - 1);

  if (POLL_DIV < 4 || (POLL_DIV >> CNT_W) != 0) begin : g_bad_poll_div
    $error("switch_poll_ctrl: POLL_DIV must be >= 4 and fit in CNT_W bits");
  end
  if (DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_debounce
    $error("switch_poll_ctrl: DEBOUNCE_CNT must be in 1..15");
  end

  state_t           state, state_next;
  logic [CNT_W-1:0] timer, timer_next;
  logic [7:0]       sw_next;
  logic [7:0]       tx_data_next;
  logic             tx_valid_next;
  logic             changed_next;
  logic             sample_en;
  logic             accept;
  logic             xfer;
  logic [7:0]       sample;
  logic             unused_readdata_hi;

  assign pio_address        = 2'b00;
  assign sample             = pio_readdata[7:0];
  assign unused_readdata_hi = ^pio_readdata[31:8];
  assign xfer               = tx_valid && tx_ready;

  switch_debounce #(
    .DEBOUNCE_CNT(DEBOUNCE_CNT)
  ) u_debounce (
    .clk      (clk),
    .reset    (reset),
    .sample_en(sample_en),
    .sample   (sample),
    .sw_state (sw_state),
    .accept   (accept)
  );

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    sw_next       = sw_state;
    tx_data_next  = tx_data;
    tx_valid_next = tx_valid;
    changed_next  = 1'b0;
    sample_en     = 1'b0;

    case (state)
      IDLE: begin
        if (!enable) begin
          timer_next = '0;
        end else if (timer == TIMER_LAST) begin
          timer_next = '0;
          state_next = WAIT;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end

      // Covers the PIO's registered readdata latency.
      WAIT: state_next = SAMPLE;

      SAMPLE: begin
        sample_en = 1'b1;
        if (accept) begin
          sw_next       = sample;
          changed_next  = 1'b1;
          tx_data_next  = nib2ascii(sample[7:4]);
          tx_valid_next = 1'b1;
          state_next    = SEND_HI;
        end else begin
          state_next = IDLE;
        end
      end

      // Each transfer loads the following byte in the same cycle.
      SEND_HI: begin
        if (xfer) begin
          tx_data_next = nib2ascii(sw_state[3:0]);
          state_next   = SEND_LO;
        end
      end

      SEND_LO: begin
        if (xfer) begin
          tx_data_next = ASCII_LF;
          state_next   = SEND_NL;
        end
      end

      SEND_NL: begin
        if (xfer) begin
          tx_valid_next = 1'b0;
          state_next    = IDLE;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      sw_state   <= '0;
      sw_changed <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      sw_state   <= sw_next;
      sw_changed <= changed_next;
      tx_valid   <= tx_valid_next;
      tx_data    <= tx_data_next;
    end
  end

`ifdef SWITCH_POLL_IRQ_EN
  // Set has priority over a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (sw_changed) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/switch_poll_ctrl.md
Name: switch_poll_ctrl

Overview:
- Polling controller for the 8-bit switch PIO slave. The PIO has a 2-bit address and 32-bit registered readdata; it returns the switches at address 0 with one-cycle latency.
- Reads the PIO periodically, debounces the sample, and publishes a stable switch state.
- On every debounced change, sends a 3-byte ASCII report (two hex digits plus LF) over a valid/ready byte stream into the UART TX path.

Parameters:
- POLL_DIV, 50000, clk cycles between poll starts; legal range ≥ 4.
- DEBOUNCE_CNT, 4, consecutive identical samples needed to accept a value; legal range 1..15.
- CNT_W, 16, width of the poll timer; must satisfy 2^CNT_W > POLL_DIV.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- enable  input  1  polling enable
- pio_address  output  2  PIO address; always 2'b00
- pio_readdata  input  32  PIO readdata; only bits [7:0] are used
- tx_data  output  8  report byte
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART TX can accept a byte
- sw_state  output  8  current debounced switch value
- sw_changed  output  1  one-cycle pulse when sw_state updates

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high, port name reset.
- Reset values: state=IDLE, timer=0, cand=0, stable_cnt=0, sw_state=0, sw_changed=0, tx_valid=0, tx_data=0. pio_address is constant 0.
- IDLE:
  - While enable=1, timer counts 0..POLL_DIV-1.
  - At terminal count, timer clears and the FSM goes to WAIT.
  - While enable=0, timer holds at 0.
- WAIT: one cycle to cover the PIO's registered readdata latency. Next state is SAMPLE.
- SAMPLE: s = pio_readdata[7:0].
  - If s == cand, stable_cnt increments, saturating at DEBOUNCE_CNT.
  - Otherwise cand <= s and stable_cnt <= 1.
  - Let new_cnt be the stable_cnt value after this update. If new_cnt == DEBOUNCE_CNT and cand' != sw_state:
    - sw_state <= cand'
    - sw_changed pulses for one cycle
    - tx_data <= hex(cand'[7:4]), tx_valid <= 1
    - next state SEND_HI
  - Otherwise return to IDLE.
  - When DEBOUNCE_CNT=1, any differing sample is accepted immediately.
- SEND_HI / SEND_LO / SEND_NL:
  - The byte is held stable while tx_valid=1; transfer happens on the clk edge where tx_valid && tx_ready.
  - On transfer, load the next byte in the same cycle (no bubble): hex(sw_state[3:0]), then 8'h0A.
  - After the LF transfers, tx_valid <= 0 and the FSM returns to IDLE.
- Hex encoding: n<10 → 8'h30+n; n≥10 → 8'h41+n-10.
- Polling during a report: timer is frozen during send states and no samples are taken. Switch changes during a report are picked up by later polls.
- enable deasserted mid-report: the report completes, then the FSM stays in IDLE.
- Reset mid-report: tx_valid=0 on the first edge with reset high; the partial report is abandoned.
- After reset with non-zero switches: the value is reported once it is debounced.

Optional Feature:
- Macro: SWITCH_POLL_IRQ_EN.
- Defined: adds ports irq (output, 1) and irq_ack (input, 1).
  - irq is set by sw_changed and cleared by irq_ack; reset value 0.
  - If set and ack occur in the same cycle, set wins.
- Undefined: no irq ports and no extra logic.

Decomposition:
- Package switch_poll_pkg holds:
  - state enum {IDLE, WAIT, SAMPLE, SEND_HI, SEND_LO, SEND_NL}
  - ASCII_0=8'h30, ASCII_A=8'h41, ASCII_LF=8'h0A
  - function nib2ascii
- Sub-module switch_debounce holds cand, stable_cnt and the accept/compare logic. The top level holds the timer, FSM and TX stream.

Test Plan (bench settings POLL_DIV=4, DEBOUNCE_CNT=3, tx_ready=1 unless stated):
- readdata=0 held for 20 polls after reset → tx_valid never asserts; sw_state=0.
- readdata=32'h5A → after the 3rd sample, sw_changed pulses once and sw_state=8'h5A. TX sequence is 8'h35, 8'h41, 8'h0A on consecutive cycles.
- 8'h5A for 2 polls, then 8'h00 → no tx_valid, no sw_changed.
- tx_ready held low for 10 cycles during SEND_HI → tx_data stays 8'h35 with tx_valid=1, and no pio sample is taken. Release tx_ready → report completes.
- readdata=32'hFFFF_FF0F → sw_state=8'h0F; TX sequence is 8'h30, 8'h46, 8'h0A.
- reset pulsed during SEND_LO → next cycle tx_valid=0 and sw_state=0; with readdata still 8'h5A, the full report is re-sent after 3 polls.
